// File: rtl/dmem_store_unit_if.sv
// rtl/dmem_store_unit_if.sv - data-cache write bus between the store unit and the cache
interface dmem_store_unit_if;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic        dmem_resp;

  modport master (
    output dmem_write, dmem_address, dmem_wdata, dmem_mbe,
    input  dmem_resp
  );

  modport slave (
    input  dmem_write, dmem_address, dmem_wdata, dmem_mbe,
    output dmem_resp
  );
endinterface

// File: rtl/dmem_store_unit.sv
// rtl/dmem_store_unit.sv - MEM-stage store writer: aligns sb/sh/sw, drives cache write, stalls until ack
module dmem_store_unit #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 st_valid,
  input  logic                 flush,
  input  logic [2:0]           funct3,
  input  logic [31:0]          addr,
  input  logic [31:0]          rs2_data,
  dmem_store_unit_if.master    dmem,
  output logic                 stall,
  output logic                 misalign,
  output logic                 illegal,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     store_count
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam logic [31:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]  state;
  logic [31:0] wd_cnt;
  logic        write_q;
  logic [31:0] address_q;
  logic [31:0] wdata_q;
  logic [3:0]  mbe_q;

  logic        legal;
  logic        aligned;
  logic [3:0]  mbe_n;
  logic [31:0] wdata_n;
  logic        req;
  logic        accept;
  logic        expire;

  always_comb begin
    legal   = 1'b1;
    aligned = 1'b1;
    mbe_n   = 4'b1111;
    wdata_n = rs2_data;
    case (funct3)
      3'b000: begin
        mbe_n   = 4'b0001 << addr[1:0];
        wdata_n = {4{rs2_data[7:0]}};
      end
      3'b001: begin
        aligned = ~addr[0];
        mbe_n   = 4'b0011 << addr[1:0];
        wdata_n = {2{rs2_data[15:0]}};
      end
      3'b010: aligned = (addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // Requests are only looked at in IDLE; flush suppresses writes and flags alike.
  assign req    = (state == S_IDLE) && st_valid && !flush;
  assign accept = req && legal && aligned;
  assign expire = (TIMEOUT_CYCLES > 0) && (wd_cnt == WD_LAST);

  // Resp takes priority over an expiring watchdog, so stall drops either way.
  assign stall = accept || ((state == S_WAIT) && !dmem.dmem_resp && !expire);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      wd_cnt      <= 32'd0;
      write_q     <= 1'b0;
      address_q   <= 32'd0;
      wdata_q     <= 32'd0;
      mbe_q       <= 4'd0;
      misalign    <= 1'b0;
      illegal     <= 1'b0;
      timeout_err <= 1'b0;
      store_count <= '0;
    end else begin
      misalign <= req && legal && !aligned;
      illegal  <= req && !legal;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state     <= S_WAIT;
            write_q   <= 1'b1;
            address_q <= {addr[31:2], 2'b00};
            wdata_q   <= wdata_n;
            mbe_q     <= mbe_n;
            wd_cnt    <= 32'd0;
          end
        end
        default: begin
          if (dmem.dmem_resp) begin
            state       <= S_IDLE;
            write_q     <= 1'b0;
            store_count <= store_count + CNT_ONE;
          end else if (expire) begin
            state       <= S_IDLE;
            write_q     <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
        end
      endcase
    end
  end

  assign dmem.dmem_write   = write_q;
  assign dmem.dmem_address = address_q;
  assign dmem.dmem_wdata   = wdata_q;
  assign dmem.dmem_mbe     = mbe_q;

endmodule

// File: tb/tb_dmem_store_unit.sv
// tb/tb_dmem_store_unit.sv - directed-vector bench for dmem_store_unit
module tb_dmem_store_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        st_valid = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic        stall, misalign, illegal, timeout_err;
  logic [31:0] store_count;

  int n_vec = 0;
  int n_err = 0;

  dmem_store_unit_if bus ();

  dmem_store_unit #(.TIMEOUT_CYCLES(4), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .st_valid    (st_valid),
    .flush       (flush),
    .funct3      (funct3),
    .addr        (addr),
    .rs2_data    (rs2_data),
    .dmem        (bus.master),
    .stall       (stall),
    .misalign    (misalign),
    .illegal     (illegal),
    .timeout_err (timeout_err),
    .store_count (store_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted store, resp after dly extra WAIT cycles; checks bus contents and stall length.
  task automatic store(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                       input int dly, input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                       input logic [3:0] exp_mbe);
    int sc;
    sc = 0;
    st_valid = 1'b1; funct3 = f3; addr = a; rs2_data = d;
    @(negedge clk); if (stall) sc++;
    tick();
    st_valid = 1'b0; funct3 = 3'b111; addr = 32'hFFFF_FFFF; rs2_data = 32'h0;
    check({tag, "_write"}, {31'd0, bus.dmem_write}, 32'd1);
    check({tag, "_addr"}, bus.dmem_address, exp_addr);
    check({tag, "_wdata"}, bus.dmem_wdata, exp_wdata);
    check({tag, "_mbe"}, {28'd0, bus.dmem_mbe}, {28'd0, exp_mbe});
    for (int i = 0; i < dly; i++) begin
      @(negedge clk); if (stall) sc++;
      tick();
    end
    bus.dmem_resp = 1'b1;
    @(negedge clk); if (stall) sc++;
    tick();
    bus.dmem_resp = 1'b0;
    check({tag, "_write_drop"}, {31'd0, bus.dmem_write}, 32'd0);
    check({tag, "_stall_cycles"}, 32'(sc), 32'(dly + 1));
  endtask

  initial begin
    int wh;
    int sc;
    bus.dmem_resp = 1'b0;

    #2;
    check("rst_write", {31'd0, bus.dmem_write}, 32'd0);
    check("rst_addr", bus.dmem_address, 32'd0);
    check("rst_wdata", bus.dmem_wdata, 32'd0);
    check("rst_mbe", {28'd0, bus.dmem_mbe}, 32'd0);
    check("rst_flags", {29'd0, misalign, illegal, timeout_err}, 32'd0);
    check("rst_count", store_count, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    store("sw", 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 3, 32'h0000_1004, 32'hDEAD_BEEF, 4'b1111);
    check("sw_count", store_count, 32'd1);

    store("sb", 3'b000, 32'h0000_2003, 32'h0000_00A5, 0, 32'h0000_2000, 32'hA5A5_A5A5, 4'b1000);
    store("sh", 3'b001, 32'h0000_2002, 32'h0000_1234, 1, 32'h0000_2000, 32'h1234_1234, 4'b1100);
    check("sbsh_count", store_count, 32'd3);

    st_valid = 1'b1; funct3 = 3'b001; addr = 32'h0000_3001; rs2_data = 32'h5555;
    @(negedge clk);
    check("mis_stall", {31'd0, stall}, 32'd0);
    tick();
    st_valid = 1'b0;
    check("mis_pulse", {31'd0, misalign}, 32'd1);
    check("mis_write", {31'd0, bus.dmem_write}, 32'd0);
    tick();
    check("mis_clear", {31'd0, misalign}, 32'd0);
    check("mis_count", store_count, 32'd3);

    st_valid = 1'b1; funct3 = 3'b011; addr = 32'h0000_3000;
    @(negedge clk);
    check("ill_stall", {31'd0, stall}, 32'd0);
    tick();
    st_valid = 1'b0;
    check("ill_pulse", {31'd0, illegal}, 32'd1);
    check("ill_write", {31'd0, bus.dmem_write}, 32'd0);
    tick();
    check("ill_clear", {31'd0, illegal}, 32'd0);

    st_valid = 1'b1; funct3 = 3'b010; addr = 32'h0000_4000; rs2_data = 32'h0BAD_F00D;
    tick();
    st_valid = 1'b0;
    wh = 0; sc = 0;
    for (int i = 0; i < 20 && bus.dmem_write; i++) begin
      @(negedge clk); if (stall) sc++;
      wh++;
      tick();
    end
    check("to_write_cycles", 32'(wh), 32'd4);
    check("to_stall_cycles", 32'(sc), 32'd3);
    check("to_err", {31'd0, timeout_err}, 32'd1);
    check("to_count", store_count, 32'd3);
    store("post_to", 3'b010, 32'h0000_5000, 32'h1111_2222, 1, 32'h0000_5000, 32'h1111_2222, 4'b1111);
    check("post_to_count", store_count, 32'd4);
    check("to_sticky", {31'd0, timeout_err}, 32'd1);

    st_valid = 1'b1; funct3 = 3'b010; addr = 32'h0000_6000; rs2_data = 32'hAAAA_0001;
    tick();
    check("b2b_w1", {31'd0, bus.dmem_write}, 32'd1);
    bus.dmem_resp = 1'b1;
    addr = 32'h0000_6004; rs2_data = 32'hAAAA_0002;
    tick();
    bus.dmem_resp = 1'b0;
    check("b2b_w0", {31'd0, bus.dmem_write}, 32'd0);
    @(negedge clk);
    check("b2b_accept_stall", {31'd0, stall}, 32'd1);
    tick();
    st_valid = 1'b0;
    check("b2b_w2", {31'd0, bus.dmem_write}, 32'd1);
    check("b2b_addr2", bus.dmem_address, 32'h0000_6004);
    check("b2b_wdata2", bus.dmem_wdata, 32'hAAAA_0002);
    bus.dmem_resp = 1'b1;
    tick();
    bus.dmem_resp = 1'b0;
    check("b2b_count", store_count, 32'd6);

    st_valid = 1'b1; funct3 = 3'b010; addr = 32'h0000_7000; rs2_data = 32'h7777_7777;
    tick();
    st_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_write", {31'd0, bus.dmem_write}, 32'd0);
    check("arst_addr", bus.dmem_address, 32'd0);
    check("arst_count", store_count, 32'd0);
    check("arst_stall", {31'd0, stall}, 32'd0);
    check("arst_err", {31'd0, timeout_err}, 32'd0);
    #1 rst = 1'b1;
    tick();
    bus.dmem_resp = 1'b1;
    tick();
    bus.dmem_resp = 1'b0;
    check("stray_resp_count", store_count, 32'd0);

    st_valid = 1'b1; flush = 1'b1; funct3 = 3'b010; addr = 32'h0000_8000;
    @(negedge clk);
    check("flush_stall", {31'd0, stall}, 32'd0);
    tick();
    check("flush_write", {31'd0, bus.dmem_write}, 32'd0);
    addr = 32'h0000_8001;
    tick();
    check("flush_noflag", {30'd0, misalign, illegal}, 32'd0);
    st_valid = 1'b0; flush = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
